// File: rtl/sp_ram_bus_adapter.sv
// sp_ram_bus_adapter
//   Slave front end for the single-port RAM wrapper. Turns a req/gnt/rvalid
//   bus with byte addresses into RAM en/addr/we/be strobes and returns exactly
//   one response per granted transfer. The RAM's read data is only valid for
//   one cycle and cannot be stalled, so responses the master is not ready for
//   are parked in a 2-entry skid FIFO. Grants are credit-limited so that FIFO
//   can never overflow. Addresses beyond the RAM depth get an error response
//   and never touch the RAM.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_i / gnt_o       request / grant (accept = req_i & gnt_o)
//   addr_i              byte address, bits [1:0] ignored
//   we_i, be_i, wdata_i write enable, byte enables, write data
//   rvalid_o / rready_i response handshake
//   rdata_o, err_o      response data (0 for writes/errors), range error flag
//   ram_*               RAM strobes; ram_rdata_i valid the cycle after ram_en_o
module sp_ram_bus_adapter #(
   parameter int ADDR_WIDTH = 17,
   parameter int NUM_WORDS  = 32768
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic [31:0]           addr_i,
   input  logic                  we_i,
   input  logic [3:0]            be_i,
   input  logic [31:0]           wdata_i,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output logic [31:0]           rdata_o,
   output logic                  err_o,
   output logic                  ram_en_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   output logic                  ram_we_o,
   output logic [3:0]            ram_be_o,
   input  logic [31:0]           ram_rdata_i
);

   logic [31:0] fifo_rdata [2];
   logic        fifo_err   [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   logic        inflight;
   logic        is_read;
   logic        is_err;

   logic [29:0] word_addr;
   logic        in_range;
   logic [1:0]  occ;
   logic        accept;
   logic        fifo_empty;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        push;
   logic        pop;

   assign word_addr = addr_i[31:2];
   assign in_range  = ({2'b00, word_addr} < 32'(NUM_WORDS));

   // Outstanding responses: parked ones plus the one arriving next cycle.
   assign occ    = count + {1'b0, inflight};
   assign gnt_o  = req_i & rst_n & (occ < 2'd2);
   assign accept = req_i & gnt_o;

   assign ram_en_o    = accept & in_range;
   assign ram_we_o    = accept & in_range & we_i;
   assign ram_addr_o  = addr_i[ADDR_WIDTH+1:2];
   assign ram_wdata_o = wdata_i;
   assign ram_be_o    = be_i;

   assign fifo_empty = (count == 2'd0);
   assign resp_rdata = (is_read & ~is_err) ? ram_rdata_i : 32'h0;
   assign resp_err   = is_err;

   // The live RAM response is presented directly only when nothing older is
   // parked; otherwise it must queue behind the FIFO head to keep order.
   assign push = rst_n & inflight & (~fifo_empty | ~rready_i);
   assign pop  = rst_n & ~fifo_empty & rready_i;

   always_comb begin
      rvalid_o = 1'b0;
      rdata_o  = 32'h0;
      err_o    = 1'b0;
      if (rst_n) begin
         if (!fifo_empty) begin
            rvalid_o = 1'b1;
            rdata_o  = fifo_rdata[rd_ptr];
            err_o    = fifo_err[rd_ptr];
         end else if (inflight) begin
            rvalid_o = 1'b1;
            rdata_o  = resp_rdata;
            err_o    = resp_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight      <= 1'b0;
         is_read       <= 1'b0;
         is_err        <= 1'b0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         count         <= 2'd0;
         fifo_rdata[0] <= 32'h0;
         fifo_rdata[1] <= 32'h0;
         fifo_err[0]   <= 1'b0;
         fifo_err[1]   <= 1'b0;
      end else begin
         inflight <= accept;
         if (accept) begin
            is_read <= ~we_i;
            is_err  <= ~in_range;
         end
         if (push) begin
            fifo_rdata[wr_ptr] <= resp_rdata;
            fifo_err[wr_ptr]   <= resp_err;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && count == 2'd2));

endmodule

// File: tb/tb_sp_ram_bus_adapter.sv
module tb_sp_ram_bus_adapter;
   localparam int AW = 17;
   localparam int NW = 32768;

   logic          clk = 1'b0;
   logic          rst_n, req, gnt, we, rvalid, rready, err, ram_en, ram_we;
   logic [31:0]   addr, wdata, rdata, ram_wdata, ram_rdata;
   logic [3:0]    be, ram_be;
   logic [AW-1:0] ram_addr;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit [31:0] rdata;
      bit        err;
   } resp_t;

   typedef struct {
      bit        req;
      bit [31:0] addr;
      bit        we;
      bit [3:0]  be;
      bit [31:0] wdata;
      bit        rready;
      bit        gnt;
      bit        rvalid;
      bit [31:0] rdata;
      bit        err;
      bit        en;
      bit [16:0] raddr;
   } vec_t;

   resp_t     q[$];
   bit [31:0] model_mem[int];
   bit [31:0] stub_mem[int];
   vec_t      tbl[$];

   sp_ram_bus_adapter #(.ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
      .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid),
      .rready_i(rready), .rdata_o(rdata), .err_o(err), .ram_en_o(ram_en),
      .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we),
      .ram_be_o(ram_be), .ram_rdata_i(ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM stub; returns noise whenever no read was issued so that
   // write/error responses must be masked by the adapter.
   always @(posedge clk) begin
      bit [31:0] w;
      int        k;
      if (ram_en && !ram_we) begin
         k = int'(ram_addr);
         ram_rdata <= stub_mem.exists(k) ? stub_mem[k] : 32'h0;
      end else begin
         ram_rdata <= $urandom;
      end
      if (ram_en && ram_we) begin
         k = int'(ram_addr);
         w = stub_mem.exists(k) ? stub_mem[k] : 32'h0;
         for (int i = 0; i < 4; i++)
            if (ram_be[i]) w[8*i +: 8] = ram_wdata[8*i +: 8];
         stub_mem[k] = w;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive at negedge, check against the reference model,
   // then advance the model to what the coming rising edge does.
   task automatic step(input bit rn, input bit r, input bit [31:0] a, input bit w,
                       input bit [3:0] b, input bit [31:0] d, input bit rr);
      bit        eg, ev, inr;
      resp_t     h, nr;
      int        word;
      bit [31:0] m;
      @(negedge clk);
      rst_n = rn; req = r; addr = a; we = w; be = b; wdata = d; rready = rr;
      #2;
      inr  = (a[31:2] < NW);
      word = int'(a[31:2]);
      eg   = rn && r && (q.size() < 2);
      ev   = rn && (q.size() > 0);
      h    = ev ? q[0] : '{32'h0, 1'b0};
      chk("gnt", gnt, 32'(eg));
      chk("rvalid", rvalid, 32'(ev));
      chk("rdata", rdata, h.rdata);
      chk("err", err, 32'(h.err));
      chk("ram_en", ram_en, 32'(eg && inr));
      if (eg && inr) begin
         chk("ram_addr", 32'(ram_addr), 32'(a[AW+1:2]));
         chk("ram_we", ram_we, 32'(w));
         if (w) begin
            chk("ram_be", 32'(ram_be), 32'(b));
            chk("ram_wdata", ram_wdata, d);
         end
      end
      if (!rn) chk("rst_ram_we", ram_we, 32'h0);
      if (!rn) begin
         q.delete();
      end else begin
         if (ev && rr) void'(q.pop_front());
         if (eg) begin
            if (!inr) begin
               nr = '{32'h0, 1'b1};
            end else begin
               m = model_mem.exists(word) ? model_mem[word] : 32'h0;
               if (w) begin
                  for (int i = 0; i < 4; i++)
                     if (b[i]) m[8*i +: 8] = d[8*i +: 8];
                  model_mem[word] = m;
                  nr = '{32'h0, 1'b0};
               end else begin
                  nr = '{m, 1'b0};
               end
            end
            q.push_back(nr);
         end
      end
   endtask

   initial begin
      bit [31:0] ra;
      rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; rready = 1'b0;

      // columns: req addr we be wdata rready | gnt rvalid rdata err en raddr
      tbl.push_back('{1, 32'h1000,     1, 4'hF, 32'hDEADBEEF, 1, 1, 0, 32'h0,        0, 1, 17'h400});
      tbl.push_back('{1, 32'h1000,     0, 4'h0, 32'h0,        1, 1, 1, 32'h0,        0, 1, 17'h400});
      tbl.push_back('{0, 32'h0,        0, 4'h0, 32'h0,        1, 0, 1, 32'hDEADBEEF, 0, 0, 17'h0});
      tbl.push_back('{1, 32'h00020000, 0, 4'h0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 17'h0});
      tbl.push_back('{0, 32'h0,        0, 4'h0, 32'h0,        1, 0, 1, 32'h0,        1, 0, 17'h0});
      tbl.push_back('{1, 32'h2000,     1, 4'hF, 32'hFFFFFFFF, 1, 1, 0, 32'h0,        0, 1, 17'h800});
      tbl.push_back('{1, 32'h2000,     1, 4'h2, 32'h0000AB00, 1, 1, 1, 32'h0,        0, 1, 17'h800});
      tbl.push_back('{1, 32'h2000,     0, 4'h0, 32'h0,        1, 1, 1, 32'h0,        0, 1, 17'h800});
      tbl.push_back('{0, 32'h0,        0, 4'h0, 32'h0,        1, 0, 1, 32'hFFFFABFF, 0, 0, 17'h0});
      tbl.push_back('{1, 32'h0,        1, 4'hF, 32'h11111111, 1, 1, 0, 32'h0,        0, 1, 17'h0});
      tbl.push_back('{1, 32'h4,        1, 4'hF, 32'h22222222, 1, 1, 1, 32'h0,        0, 1, 17'h1});
      tbl.push_back('{1, 32'h8,        1, 4'hF, 32'h33333333, 1, 1, 1, 32'h0,        0, 1, 17'h2});
      tbl.push_back('{1, 32'h0,        0, 4'h0, 32'h0,        1, 1, 1, 32'h0,        0, 1, 17'h0});
      tbl.push_back('{1, 32'h4,        0, 4'h0, 32'h0,        1, 1, 1, 32'h11111111, 0, 1, 17'h1});
      tbl.push_back('{1, 32'h8,        0, 4'h0, 32'h0,        1, 1, 1, 32'h22222222, 0, 1, 17'h2});
      tbl.push_back('{0, 32'h0,        0, 4'h0, 32'h0,        1, 0, 1, 32'h33333333, 0, 0, 17'h0});
      tbl.push_back('{0, 32'h0,        0, 4'h0, 32'h0,        1, 0, 0, 32'h0,        0, 0, 17'h0});

      // Reset state, with a request pending to show gnt is held low.
      step(0, 1, 32'h0, 0, 4'h0, 32'h0, 1);
      step(0, 1, 32'h4, 1, 4'hF, 32'h5, 0);
      chk("reset_gnt", gnt, 32'h0);
      chk("reset_rvalid", rvalid, 32'h0);

      foreach (tbl[i]) begin
         step(1, tbl[i].req, tbl[i].addr, tbl[i].we, tbl[i].be, tbl[i].wdata, tbl[i].rready);
         chk($sformatf("vec%0d_gnt", i), gnt, 32'(tbl[i].gnt));
         chk($sformatf("vec%0d_rvalid", i), rvalid, 32'(tbl[i].rvalid));
         chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].rdata);
         chk($sformatf("vec%0d_err", i), err, 32'(tbl[i].err));
         chk($sformatf("vec%0d_en", i), ram_en, 32'(tbl[i].en));
         if (tbl[i].en) chk($sformatf("vec%0d_raddr", i), 32'(ram_addr), 32'(tbl[i].raddr));
      end

      // Back-pressure: two grants, then gnt low while data holds stable.
      step(1, 1, 32'h0, 0, 4'h0, 32'h0, 0);
      chk("bp_gnt0", gnt, 32'h1);
      step(1, 1, 32'h0, 0, 4'h0, 32'h0, 0);
      chk("bp_gnt1", gnt, 32'h1);
      step(1, 1, 32'h0, 0, 4'h0, 32'h0, 0);
      chk("bp_gnt2", gnt, 32'h0);
      chk("bp_hold2", rdata, 32'h11111111);
      step(1, 1, 32'h0, 0, 4'h0, 32'h0, 0);
      chk("bp_gnt3", gnt, 32'h0);
      chk("bp_hold3", rdata, 32'h11111111);
      step(1, 1, 32'h4, 0, 4'h0, 32'h0, 1);
      chk("bp_full_gnt", gnt, 32'h0);
      step(1, 1, 32'h4, 0, 4'h0, 32'h0, 1);
      chk("bp_resume_gnt", gnt, 32'h1);
      chk("bp_second", rdata, 32'h11111111);
      step(1, 1, 32'h8, 0, 4'h0, 32'h0, 1);
      chk("bp_bypass", rdata, 32'h22222222);
      for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 4'h0, 32'h0, 1);

      // Reset with one response parked and one in flight.
      step(1, 1, 32'h4, 0, 4'h0, 32'h0, 0);
      step(1, 1, 32'h8, 0, 4'h0, 32'h0, 0);
      step(0, 1, 32'h0, 0, 4'h0, 32'h0, 0);
      chk("rst_mid_rvalid", rvalid, 32'h0);
      chk("rst_mid_gnt", gnt, 32'h0);
      chk("rst_mid_rdata", rdata, 32'h0);
      step(1, 0, 32'h0, 0, 4'h0, 32'h0, 1);
      chk("post_rst_rvalid", rvalid, 32'h0);
      step(1, 1, 32'h4, 0, 4'h0, 32'h0, 1);
      step(1, 0, 32'h0, 0, 4'h0, 32'h0, 1);
      chk("post_rst_read", rdata, 32'h22222222);

      // Randomised traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 9))
            0:       ra = {$urandom_range(32767, 32768), 2'($urandom)};
            1:       ra = $urandom;
            default: ra = {26'h0, 4'($urandom), 2'($urandom)};
         endcase
         step(($urandom_range(0, 79) != 0), ($urandom_range(0, 3) != 0), ra,
              1'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 0, 4'h0, 32'h0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
